// File: rtl/reg_status_file_pkg.sv
// Shared widths and reserved ids for the register status file.
package reg_status_file_pkg;

  localparam int ROB_ID_W  = 5;
  localparam int REG_ID_W  = 5;
  localparam int DATA_W    = 32;
  localparam int REG_COUNT = 32;

  localparam logic [ROB_ID_W-1:0] ROB_NONE = '0;

  function automatic logic is_x0(input logic [REG_ID_W-1:0] id);
    return id == '0;
  endfunction

endpackage

// File: rtl/reg_status_file_read_port.sv
// One operand read port: x0 masking and, with REGFILE_BYPASS_EN,
// a commit-to-read bypass mux.
module reg_status_file_read_port
  import reg_status_file_pkg::*;
#(
  parameter int ROB_W = ROB_ID_W
) (
  input  logic [REG_ID_W-1:0] rs_id,
  input  logic [DATA_W-1:0]   reg_value,
  input  logic [ROB_W-1:0]    reg_tag,
  input  logic                commit_enabled,
  input  logic [REG_ID_W-1:0] commit_reg_id,
  input  logic [DATA_W-1:0]   commit_data,
  input  logic [ROB_W-1:0]    commit_rob_id,
  output logic [DATA_W-1:0]   rs_value,
  output logic [ROB_W-1:0]    rs_rob_id
);

`ifndef REGFILE_BYPASS_EN
  logic unused_commit;
  assign unused_commit = ^{commit_enabled, commit_reg_id,
                           commit_data, commit_rob_id};
`endif

  always_comb begin
    rs_value  = reg_value;
    rs_rob_id = reg_tag;
`ifdef REGFILE_BYPASS_EN
    if (commit_enabled &&
        commit_reg_id == rs_id &&
        reg_tag == commit_rob_id) begin
      rs_value  = commit_data;
      rs_rob_id = '0;
    end
`endif
    if (is_x0(rs_id)) begin
      rs_value  = '0;
      rs_rob_id = '0;
    end
  end

endmodule

// File: rtl/reg_status_file.sv
// Architectural regs plus rename tags fed by issue and ROB commit.
// Optional REGFILE_BYPASS_EN adds zero-cycle commit-to-read.
module reg_status_file
  import reg_status_file_pkg::*;
#(
  parameter int ROB_W    = ROB_ID_W,
  parameter int NUM_REGS = REG_COUNT
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                flush_in,
  input  logic                commit_enabled,
  input  logic [REG_ID_W-1:0] commit_reg_id,
  input  logic [DATA_W-1:0]   commit_data,
  input  logic [ROB_W-1:0]    commit_rob_id,
  input  logic                issue_enabled,
  input  logic [REG_ID_W-1:0] issue_reg_id,
  input  logic [ROB_W-1:0]    issue_rob_id,
  input  logic [REG_ID_W-1:0] rs1_id,
  input  logic [REG_ID_W-1:0] rs2_id,
  output logic [DATA_W-1:0]   rs1_value,
  output logic [ROB_W-1:0]    rs1_rob_id,
  output logic [DATA_W-1:0]   rs2_value,
  output logic [ROB_W-1:0]    rs2_rob_id
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ROB_W-1:0]  tags [NUM_REGS];

  logic commit_wr;
  logic issue_wr;
  logic tag_clr;

  assign commit_wr = commit_enabled && !is_x0(commit_reg_id);
  assign issue_wr  = issue_enabled && !flush_in &&
                     !is_x0(issue_reg_id);
  // A same-reg issue re-owns the tag, so the commit must not clear it
  assign tag_clr   = commit_wr &&
                     tags[commit_reg_id] == commit_rob_id &&
                     !(issue_enabled &&
                       issue_reg_id == commit_reg_id);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
    end else begin
      if (commit_wr)
        regs[commit_reg_id] <= commit_data;
      if (flush_in) begin
        for (int i = 0; i < NUM_REGS; i++)
          tags[i] <= '0;
      end else begin
        if (tag_clr)
          tags[commit_reg_id] <= '0;
        if (issue_wr)
          tags[issue_reg_id] <= issue_rob_id;
      end
    end
  end

  reg_status_file_read_port #(
    .ROB_W(ROB_W)
  ) u_rs1 (
    .rs_id         (rs1_id),
    .reg_value     (regs[rs1_id]),
    .reg_tag       (tags[rs1_id]),
    .commit_enabled(commit_enabled),
    .commit_reg_id (commit_reg_id),
    .commit_data   (commit_data),
    .commit_rob_id (commit_rob_id),
    .rs_value      (rs1_value),
    .rs_rob_id     (rs1_rob_id)
  );

  reg_status_file_read_port #(
    .ROB_W(ROB_W)
  ) u_rs2 (
    .rs_id         (rs2_id),
    .reg_value     (regs[rs2_id]),
    .reg_tag       (tags[rs2_id]),
    .commit_enabled(commit_enabled),
    .commit_reg_id (commit_reg_id),
    .commit_data   (commit_data),
    .commit_rob_id (commit_rob_id),
    .rs_value      (rs2_value),
    .rs_rob_id     (rs2_rob_id)
  );

endmodule
